// File: rtl/ecc_arith_pkg.sv
// Shared constants and types for the ECC modular arithmetic datapath:
// the two moduli, word geometry and the operand loader state encoding.
package ecc_arith_pkg;

  localparam int WORD_W = 32;
  localparam int WORD_N = 8;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_N - 1);

  localparam logic [255:0] MP0 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [255:0] MP1 =
    256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;

  typedef enum logic [2:0] {
    LD_LOAD = 3'b001,
    LD_CMP  = 3'b010,
    LD_DONE = 3'b100
  } ld_state_e;

  // Selects one 32-bit chunk of the chosen modulus, least-significant chunk at idx 0.
  function automatic logic [WORD_W-1:0] mod_chunk(input logic sel,
                                                  input logic [CNT_W-1:0] idx);
    logic [255:0] m;
    m = sel ? MP1 : MP0;
    return m[WORD_W*idx +: WORD_W];
  endfunction

endpackage

// File: rtl/mod_arith_ld_cu.sv
// Control unit of the operand loader: LOAD/CMP/DONE sequencing, the shared
// word/chunk counter and the borrow register of the serial range check.
module mod_arith_ld_cu
  import ecc_arith_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic             b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o,
  output logic             borrow_o
);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             clear;
  logic             accept;

  assign clear  = rst_i | clr_i;
  assign accept = valid_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (clear) state_q <= LD_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_LOAD: if (valid_i && cnt_q == LAST_IDX) state_d = LD_CMP;
      LD_CMP:  if (cnt_q == LAST_IDX)            state_d = LD_DONE;
      LD_DONE:                                   state_d = LD_LOAD;
      default:                                   state_d = LD_LOAD;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      LD_LOAD: ready_o = 1'b1;
      LD_CMP:  busy_o  = 1'b1;
      LD_DONE: done_o  = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  // The 3-bit counter wraps 7 -> 0 on its own, which is exactly the
  // hand-over between the load phase and the compare phase.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      if (accept || busy_o) cnt_q <= cnt_q + 1'b1;
      if (busy_o)           borrow_q <= last_o ? 1'b0 : b_i;
    end
  end

  assign cnt_o    = cnt_q;
  assign last_o   = busy_o && (cnt_q == LAST_IDX);
  assign borrow_o = borrow_q;

endmodule

// File: rtl/mod_arith_ld.sv
// Operand loader: collects a 256-bit operand word by word, range-checks it
// against the selected modulus and presents it as (xp, xn) with xp - xn in [0, M).
module mod_arith_ld
  import ecc_arith_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_clr,
  input  logic                flg_mod,
  input  logic                wr_valid,
  input  logic [WORD_W-1:0]   wr_data,
  output logic                wr_ready,
  output logic                ld_busy,
  output logic                ld_done,
  output logic                ld_ovf,
  output logic [255:0]        xp,
  output logic [255:0]        xn
);

  logic [255:0]      xp_q, xn_q;
  logic              ovf_q;
  logic              mod_sel_q;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic              borrow;
  logic              b;
  logic              accept;
  logic              clear;
  logic [WORD_W-1:0] chunk;

  mod_arith_ld_cu u_cu (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (ld_clr),
    .valid_i  (wr_valid),
    .b_i      (b),
    .ready_o  (wr_ready),
    .busy_o   (ld_busy),
    .done_o   (ld_done),
    .cnt_o    (cnt),
    .last_o   (last),
    .borrow_o (borrow)
  );

  assign clear  = rst | ld_clr;
  assign accept = wr_valid & wr_ready;
  assign chunk  = mod_chunk(mod_sel_q, cnt);

  // Borrow-out of xp_chunk - chunk - borrow; only the borrow is needed,
  // since the difference itself is never stored.
  assign b = (xp_q[WORD_W-1:0] < chunk) ||
             ((xp_q[WORD_W-1:0] == chunk) && borrow);

  always_ff @(posedge clk) begin
    if (clear) begin
      xp_q      <= '0;
      xn_q      <= '0;
      ovf_q     <= 1'b0;
      mod_sel_q <= 1'b0;
    end else if (accept) begin
      xp_q <= {wr_data, xp_q[255:WORD_W]};
      if (cnt == '0) begin
        xn_q  <= '0;
        ovf_q <= 1'b0;
      end
      if (cnt == LAST_IDX) mod_sel_q <= flg_mod;
    end else if (ld_busy) begin
      xp_q <= {xp_q[WORD_W-1:0], xp_q[255:WORD_W]};
      if (last && !b) begin
        xn_q  <= mod_sel_q ? MP1 : MP0;
        ovf_q <= 1'b1;
      end
    end
  end

  assign xp     = xp_q;
  assign xn     = xn_q;
  assign ld_ovf = ovf_q;

endmodule

// File: tb/tb_mod_arith_ld.sv
// Self-checking bench for mod_arith_ld: directed and randomized operands
// compared against a plain-arithmetic reference (xn = x >= M ? M : 0).
module tb_mod_arith_ld;

  localparam logic [255:0] TB_MP0 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [255:0] TB_MP1 =
    256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;

  logic         clk = 1'b0;
  logic         rst, ld_clr, flg_mod, wr_valid;
  logic [31:0]  wr_data;
  logic         wr_ready, ld_busy, ld_done, ld_ovf;
  logic [255:0] xp, xn;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  mod_arith_ld dut (
    .clk      (clk),
    .rst      (rst),
    .ld_clr   (ld_clr),
    .flg_mod  (flg_mod),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_ovf   (ld_ovf),
    .xp       (xp),
    .xn       (xn)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".wr_ready"}, 256'(wr_ready), 256'd1);
    checkOutput({tag, ".ld_busy"},  256'(ld_busy),  256'd0);
    checkOutput({tag, ".ld_done"},  256'(ld_done),  256'd0);
    checkOutput({tag, ".ld_ovf"},   256'(ld_ovf),   256'd0);
    checkOutput({tag, ".xp"},       xp,             256'd0);
    checkOutput({tag, ".xn"},       xn,             256'd0);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Operands clustered around the modulus so both outcomes get exercised.
  function automatic logic [255:0] randOperand(input logic sel);
    logic [255:0] m;
    m = sel ? TB_MP1 : TB_MP0;
    case ($urandom_range(0, 3))
      0:       return rand256();
      1:       return m + 256'($urandom_range(0, 1000));
      2:       return m - 256'($urandom_range(1, 1000));
      default: return {32'hFFFFFFFF, rand256() >> 32};
    endcase
  endfunction

  // Loads one operand starting at a negedge; returns at the negedge one
  // cycle after ld_done (or right after a reset injected in CMP cycle rstCycle).
  task automatic applyStimulus(input string tag, input logic [255:0] x,
                               input logic sel, input bit gaps,
                               input bit toggleMod, input int rstCycle);
    logic [255:0] m, expXn;
    logic         expOvf;
    int           n;
    m      = sel ? TB_MP1 : TB_MP0;
    expOvf = (x >= m);
    expXn  = expOvf ? m : 256'd0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (gaps && n < 3 && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0;
        @(negedge clk);
        n++;
      end
      n = 0;
      while (!wr_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput({tag, ".wr_ready_word"}, 256'(wr_ready), 256'd1);
      wr_valid = 1'b1;
      wr_data  = x[32*k +: 32];
      flg_mod  = sel;
      @(negedge clk);
    end
    wr_data = $urandom;
    checkOutput({tag, ".busy_cmp"},  256'(ld_busy),  256'd1);
    checkOutput({tag, ".ready_cmp"}, 256'(wr_ready), 256'd0);
    for (int k = 1; k <= 7; k++) begin
      if (toggleMod) flg_mod = ~flg_mod;
      if (rstCycle == k) begin
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b0;
        checkReset({tag, ".rst"});
        n = 0;
        repeat (12) begin
          @(negedge clk);
          if (ld_done) n++;
        end
        checkOutput({tag, ".no_done_after_rst"}, 256'(n), 256'd0);
        return;
      end
      @(negedge clk);
      checkOutput({tag, ".done_early"}, 256'(ld_done), 256'd0);
      wr_data = $urandom;
    end
    @(negedge clk);
    checkOutput({tag, ".ld_done"}, 256'(ld_done), 256'd1);
    checkOutput({tag, ".xp"},      xp,            x);
    checkOutput({tag, ".xn"},      xn,            expXn);
    checkOutput({tag, ".ld_ovf"},  256'(ld_ovf),  256'(expOvf));
    @(negedge clk);
    checkOutput({tag, ".done_pulse"}, 256'(ld_done),  256'd0);
    checkOutput({tag, ".ready_back"}, 256'(wr_ready), 256'd1);
    checkOutput({tag, ".xn_hold"},    xn,             expXn);
    wr_valid = 1'b0;
    flg_mod  = sel;
  endtask

  initial begin
    logic [255:0] x;
    logic         sel;
    int           doneSeen;

    rst = 1'b1; ld_clr = 1'b0; flg_mod = 1'b0; wr_valid = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("x1_mp0",      256'd1,         1'b0, 1'b0, 1'b0, 0);
    applyStimulus("mp0_mp0",     TB_MP0,         1'b0, 1'b0, 1'b0, 0);
    applyStimulus("ones_mp1",    {256{1'b1}},    1'b1, 1'b0, 1'b1, 0);
    applyStimulus("mp1m1",       TB_MP1 - 1,     1'b1, 1'b0, 1'b0, 0);
    applyStimulus("mp1m1_gaps",  TB_MP1 - 1,     1'b1, 1'b1, 1'b0, 0);
    applyStimulus("mp1_mp1",     TB_MP1,         1'b1, 1'b0, 1'b0, 0);
    applyStimulus("mp0m1_mp0",   TB_MP0 - 1,     1'b0, 1'b0, 1'b0, 0);

    // Abort after five words; ld_clr wins over a simultaneous valid word.
    x = rand256();
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1'b1;
      wr_data  = x[32*k +: 32];
      @(negedge clk);
    end
    ld_clr   = 1'b1;
    wr_valid = 1'b1;
    wr_data  = $urandom;
    @(negedge clk);
    ld_clr   = 1'b0;
    wr_valid = 1'b0;
    checkReset("clr");
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ld_done) doneSeen++;
    end
    checkOutput("clr.no_done", 256'(doneSeen), 256'd0);
    applyStimulus("x7_after_clr", 256'd7, 1'b0, 1'b0, 1'b0, 0);

    applyStimulus("pre_rst",     TB_MP0,         1'b0, 1'b0, 1'b0, 0);
    applyStimulus("rst_cmp4",    TB_MP0 + 5,     1'b0, 1'b0, 1'b0, 4);
    applyStimulus("b2b_mp0p5",   TB_MP0 + 5,     1'b0, 1'b0, 1'b0, 0);
    applyStimulus("b2b_x3",      256'd3,         1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      sel = 1'($urandom_range(0, 1));
      x   = randOperand(sel);
      applyStimulus($sformatf("rand%0d", i), x, sel,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
